// File: rtl/mc_controller_if.sv
// Control bus between the multicycle control FSM and its datapath.
// The master side is the controller: it receives the opcode, the ALU zero
// flag and the memory handshake, and drives every datapath control line.
interface mc_controller_if;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, Zero, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state
  );

  modport slave (
    output op, Zero, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: sequences fetch, decode, memory access,
// execute and writeback over a shared datapath, waits on the memory ready
// handshake and parks in a trap state on an unknown opcode.
module mc_controller (
  input  logic             clk,
  input  logic             resetn,
  mc_controller_if.master  bus
);
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       pc_update_s, branch_s;
  logic       adr_src_s, ir_write_s, mem_write_s, reg_write_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, imm_src_s;

  // State register and sticky illegal-opcode flag; reset aborts any instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_d = illegal_q | (state_q == S_TRAP);

  // Next-state logic; unused codes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; anything not named for a state stays 0
  always_comb begin
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = bus.mem_ready;
        pc_update_s  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD:  adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
      end
      S_ALUWB:    reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        branch_s    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode directly
  always_comb begin
    imm_src_s = 2'b00;
    case (bus.op)
      OP_SW:   imm_src_s = 2'b01;
      OP_BEQ:  imm_src_s = 2'b10;
      OP_JAL:  imm_src_s = 2'b11;
      default: imm_src_s = 2'b00;
    endcase
  end

  // Write enables are held off for as long as reset is asserted
  assign bus.PCWrite   = resetn & (pc_update_s | (branch_s & bus.Zero));
  assign bus.IRWrite   = resetn & ir_write_s;
  assign bus.MemWrite  = resetn & mem_write_s;
  assign bus.RegWrite  = resetn & reg_write_s;
  assign bus.AdrSrc    = adr_src_s;
  assign bus.ResultSrc = result_src_s;
  assign bus.ALUSrcA   = alu_src_a_s;
  assign bus.ALUSrcB   = alu_src_b_s;
  assign bus.ALUOp     = alu_op_s;
  assign bus.ImmSrc    = imm_src_s;
  assign bus.illegal   = illegal_q | (state_q == S_TRAP);
  assign bus.state     = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus side walks each
// instruction through its expected phase list and queues the expected
// control word per cycle; a monitor compares on every falling edge.
module tb_mc_controller;
  logic clk;
  logic resetn;
  mc_controller_if bus ();

  mc_controller dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [19:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  // Expected control word for one cycle, straight from the per-state table
  function automatic logic [19:0] exp_vec(input int st, input logic [6:0] op,
                                          input logic z, input logic mr,
                                          input logic rn);
    logic pcw, adr, irw, mw, rw, ill;
    logic [1:0] res, sa, sb, aop, imm;
    logic [3:0] st4;
    pcw = 1'b0; adr = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
    case (st)
      0:  begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin res = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      8:  rw = 1'b1;
      9:  begin sa = 2'b10; aop = 2'b01; pcw = z; end
      10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    if (!rn) begin pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; end
    if (op == OP_SW) imm = 2'b01;
    else if (op == OP_BEQ) imm = 2'b10;
    else if (op == OP_JAL) imm = 2'b11;
    else imm = 2'b00;
    ill = (st == 11);
    st4 = st[3:0];
    return {st4, pcw, adr, irw, mw, rw, res, sa, sb, aop, imm, ill};
  endfunction

  // Monitor: compare the DUT's control word against the next queued one
  always @(negedge clk) begin
    logic [19:0] act, exp;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      act = {bus.state, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite,
             bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
             bus.ImmSrc, bus.illegal};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL ctrl_state%0d actual=%h expected=%h at %0t",
                 exp[19:16], act, exp, $time);
      end
    end
  end

  task automatic drive_cycle(input int st, input logic [6:0] op, input logic z,
                             input logic mr, input logic rn);
    bus.op = op;
    bus.Zero = z;
    bus.mem_ready = mr;
    resetn = rn;
    sb_q.push_back(exp_vec(st, op, z, mr, rn));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      drive_cycle(0, r[6:0], r[8], r[9], 1'b0);
    end
    resetn = 1'b1;
  endtask

  // mrmode: 0 random ready, 1 always ready, 2 two stall cycles in MEMWRITE.
  // zsel: 0/1 fixed Zero, 2 random. abort_at: phase index to reset in (-1 none).
  task automatic run_instr(input logic [6:0] iop, input int mrmode,
                           input int zsel, input int abort_at);
    int ph[$];
    int st, wcnt;
    logic mr, z;
    logic [6:0] opd;
    logic [31:0] r;
    case (iop)
      OP_LW:   ph = '{0, 1, 2, 3, 4};
      OP_SW:   ph = '{0, 1, 2, 5};
      OP_R:    ph = '{0, 1, 6, 8};
      OP_I:    ph = '{0, 1, 7, 8};
      OP_JAL:  ph = '{0, 1, 10, 8};
      OP_BEQ:  ph = '{0, 1, 9};
      default: begin
        ph = '{0, 1};
        for (int k = 0; k < 10; k++) ph.push_back(11);
      end
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      st = ph[i];
      wcnt = 0;
      forever begin
        if (i == abort_at && wcnt == 1) begin
          do_reset(2);
          return;
        end
        case (mrmode)
          1:       mr = 1'b1;
          2:       mr = !(st == 5 && wcnt < 2);
          default: mr = ($urandom_range(0, 3) != 0);
        endcase
        z = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
        r = $urandom();
        opd = (st == 1 || st == 2) ? iop : r[6:0];
        drive_cycle(st, opd, z, mr, 1'b1);
        wcnt++;
        if (!((st == 0 || st == 3 || st == 5) && !mr)) break;
      end
    end
  endtask

  // Stimulus: directed instructions, a random stream, aborts and the trap
  initial begin
    logic [6:0] legal[6];
    legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    resetn = 1'b0;
    bus.op = 7'd0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);
    run_instr(OP_LW, 1, 0, -1);
    run_instr(OP_SW, 2, 0, -1);
    run_instr(OP_BEQ, 1, 1, -1);
    run_instr(OP_BEQ, 1, 0, -1);
    run_instr(OP_JAL, 1, 0, -1);
    run_instr(OP_R, 1, 2, -1);
    run_instr(OP_I, 1, 2, -1);
    for (int n = 0; n < 40; n++)
      run_instr(legal[$urandom_range(0, 5)], 0, 2, -1);
    run_instr(OP_SW, 2, 0, 3);
    run_instr(OP_LW, 0, 2, -1);
    run_instr(7'b1111111, 1, 2, -1);
    do_reset(2);
    run_instr(OP_LW, 1, 0, -1);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound the whole run
  initial begin
    #1000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the RISC-V multicycle core variant. It sequences a shared-memory datapath (PC, instruction register, register file, single ALU, one memory port) across several cycles per instruction. It covers the same opcode set as the single-cycle main decoder (lw, sw, R-type, I-type ALU, beq, jal) and adds a memory ready handshake and an illegal-opcode trap state.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode field of the instruction register; valid from DECODE onward.
- `Zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  PC load enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `IRWrite`  out  1  load instruction register and OldPC.
- `MemWrite`  out  1  memory write strobe.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  00 ALUOut, 01 read data, 10 ALU result.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1 data.
- `ALUSrcB`  out  2  00 rs2 data, 01 immediate, 10 constant 4.
- `ALUOp`  out  2  00 add, 01 subtract (branch), 10 decode funct.
- `ImmSrc`  out  2  00 I, 01 S, 10 B, 11 J.
- `illegal`  out  1  sticky: set in TRAP.
- `state`  out  4  current state code, for debug.

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11. Codes 12–15 are unreachable; if reached, go to FETCH on the next edge.
- Outputs are a combinational function of `state`. Exceptions: `ImmSrc` depends on `op`, and the gating below depends on `Zero` and `mem_ready`. Every output not listed for a state is 0. No x values are driven.
- Per-state outputs:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready. PCUpdate=mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held every cycle in this state).
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - TRAP: all enables 0, illegal=1.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc by `op`: 0000011/0010011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, other → 00.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay in FETCH.
  - DECODE by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - other → TRAP
  - MEMADR → MEMREAD if op=0000011, else → MEMWRITE.
  - MEMREAD → MEMWB when mem_ready, else stay.
  - MEMWRITE → FETCH when mem_ready, else stay.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, ALUWB, BEQ → FETCH.
  - TRAP → TRAP until reset.

## Timing
- Reset: resetn low forces state=FETCH asynchronously and clears `illegal`. While resetn is low, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. Other outputs show FETCH values.
- First fetch can complete on the first rising edge after resetn deasserts.
- Cycles per instruction with mem_ready held 1: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. Write enables stay 0 during the wait, except MemWrite, which stays held.
- Reset mid-instruction (any state, including TRAP) aborts the instruction. No write enable is asserted after resetn falls.
- `op` is sampled only in DECODE and MEMADR; changes in other states are ignored.

## Test plan
- Reset with resetn=0 for 3 cycles, then release with mem_ready=1 → state=0, illegal=0 and all write enables 0 during reset; state=1 one cycle after the first edge.
- lw (op=0000011), mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; ImmSrc=00.
- sw (op=0100011), mem_ready low for 2 cycles in MEMWRITE → states 0,1,2,5,5,5,0; MemWrite=1 for all 3 cycles in state 5; ImmSrc=01.
- beq (op=1100011), first with Zero=1 then with Zero=0 → states 0,1,9,0 both times; PCWrite=1 in state 9 only when Zero=1.
- jal (op=1101111) → states 0,1,10,8,0; PCWrite=1 in state 10; RegWrite=1 in state 8; ImmSrc=11.
- op=1111111 → state 11 after DECODE, illegal=1 and held for 10 cycles; resetn pulse → state 0, illegal=0.
